reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 56 +++++
 tb/tb_reg_file_mp.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: 2-read/1-write register file with a per-register busy scoreboard.
// Define REG_FILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [DATA_W-1:0] IN,
   input  logic [ADDR_W-1:0] INADDRESS,
   input  logic              WRITE,
   input  logic [ADDR_W-1:0] OUT1ADDRESS,
   input  logic [ADDR_W-1:0] OUT2ADDRESS,
   output logic [DATA_W-1:0] OUT1,
   output logic [DATA_W-1:0] OUT2,
   output logic              BUSY1,
   output logic              BUSY2,
   input  logic              RSV,
   input  logic [ADDR_W-1:0] RSVADDRESS,
   input  logic              FLUSH
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wr_ok, rsv_ok, z1, z2, byp1, byp2;
   assign wr_ok  = WRITE && !(ZERO_REG != 0 && INADDRESS == '0);
   assign rsv_ok = RSV && !(ZERO_REG != 0 && RSVADDRESS == '0);
   assign z1     = ZERO_REG != 0 && OUT1ADDRESS == '0;
   assign z2     = ZERO_REG != 0 && OUT2ADDRESS == '0;
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         if (wr_ok) regs[INADDRESS] <= IN;
         // reserve beats a same-cycle write; flush beats both
         for (int i = 0; i < DEPTH; i++)
            busy[i] <= FLUSH ? 1'b0 :
                       (rsv_ok && RSVADDRESS == ADDR_W'(i)) ? 1'b1 :
                       (wr_ok && INADDRESS == ADDR_W'(i)) ? 1'b0 : busy[i];
      end
`ifdef REG_FILE_MP_BYPASS_EN
   assign byp1 = wr_ok && INADDRESS == OUT1ADDRESS && !(RSV && RSVADDRESS == OUT1ADDRESS);
   assign byp2 = wr_ok && INADDRESS == OUT2ADDRESS && !(RSV && RSVADDRESS == OUT2ADDRESS);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif
   always_comb begin
      OUT1  = (!RESET_N || z1) ? '0 : byp1 ? IN : regs[OUT1ADDRESS];
      OUT2  = (!RESET_N || z2) ? '0 : byp2 ? IN : regs[OUT2ADDRESS];
      BUSY1 = (!RESET_N || z1 || byp1) ? 1'b0 : busy[OUT1ADDRESS];
      BUSY2 = (!RESET_N || z2 || byp2) ? 1'b0 : busy[OUT2ADDRESS];
   end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: vector table, directed corner cases and random run against a model.
module tb_reg_file_mp;
   logic        CLK = 1'b0, RESET_N = 1'b0;
   logic [31:0] IN = '0;
   logic [4:0]  INADDRESS = '0, OUT1ADDRESS = '0, OUT2ADDRESS = '0, RSVADDRESS = '0;
   logic        WRITE = 1'b0, RSV = 1'b0, FLUSH = 1'b0;
   logic [31:0] OUT1, OUT2;
   logic        BUSY1, BUSY2;
   logic [63:0] p_in = '0;
   logic [2:0]  p_ia = '0, p_a1 = '0, p_a2 = '0, p_ra = '0;
   logic        p_w = 1'b0, p_r = 1'b0, p_f = 1'b0;
   logic [63:0] p_o1, p_o2;
   logic        p_b1, p_b2;
   int errors = 0, checks = 0;
   logic [31:0] mreg [32];
   logic        mbusy [32];
`ifdef REG_FILE_MP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   typedef struct {
      logic w; logic [4:0] ia; logic [31:0] d; logic r; logic [4:0] ra; logic f;
      logic [4:0] a1, a2; logic [31:0] e1, e2; logic b1, b2;
   } vec_t;
   vec_t tbl [14];

   reg_file_mp dut (.CLK(CLK), .RESET_N(RESET_N), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
      .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(OUT1), .OUT2(OUT2),
      .BUSY1(BUSY1), .BUSY2(BUSY2), .RSV(RSV), .RSVADDRESS(RSVADDRESS), .FLUSH(FLUSH));
   reg_file_mp #(.DATA_W(64), .ADDR_W(3), .ZERO_REG(0)) dut64 (.CLK(CLK), .RESET_N(RESET_N),
      .IN(p_in), .INADDRESS(p_ia), .WRITE(p_w), .OUT1ADDRESS(p_a1), .OUT2ADDRESS(p_a2),
      .OUT1(p_o1), .OUT2(p_o2), .BUSY1(p_b1), .BUSY2(p_b2), .RSV(p_r), .RSVADDRESS(p_ra), .FLUSH(p_f));

   always #50 CLK = ~CLK;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input logic w, input logic [4:0] ia, input logic [31:0] d,
                        input logic r, input logic [4:0] ra, input logic f);
      WRITE = w; INADDRESS = ia; IN = d; RSV = r; RSVADDRESS = ra; FLUSH = f;
   endtask

   task automatic model_reset;
      for (int i = 0; i < 32; i++) begin mreg[i] = '0; mbusy[i] = 1'b0; end
   endtask

   task automatic model_edge;
      if (RESET_N) begin
         if (WRITE && INADDRESS != 0) mreg[INADDRESS] = IN;
         if (FLUSH) for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
         else begin
            if (WRITE) mbusy[INADDRESS] = 1'b0;
            if (RSV && RSVADDRESS != 0) mbusy[RSVADDRESS] = 1'b1;
         end
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic mread(input logic [4:0] a, output logic [31:0] d, output logic b);
      if (!RESET_N || a == 0) begin d = '0; b = 1'b0; end
      else if (BYP && WRITE && INADDRESS == a && !(RSV && RSVADDRESS == a)) begin d = IN; b = 1'b0; end
      else begin d = mreg[a]; b = mbusy[a]; end
   endtask

   task automatic check_reads(input string tag);
      logic [31:0] d; logic b;
      #1;
      mread(OUT1ADDRESS, d, b);
      chk({tag, "_out1"}, OUT1, d); chk({tag, "_busy1"}, BUSY1, b);
      mread(OUT2ADDRESS, d, b);
      chk({tag, "_out2"}, OUT2, d); chk({tag, "_busy2"}, BUSY2, b);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd7, 5'd5, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 5'd7, 32'h55,       1'b0, 5'd0, 1'b0, 5'd7, 5'd5, 32'h55, 32'hDEADBEEF, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 5'd9, 32'hA5,       1'b1, 5'd9, 1'b0, 5'd9, 5'd7, 32'hA5, 32'h55, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b1, 5'd9, 5'd5, 32'hA5, 32'hDEADBEEF, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b0, 5'd0, 5'd9, 32'h0, 32'hA5, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 1'b0, 5'd4, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 5'd4, 32'h77,       1'b0, 5'd0, 1'b1, 5'd4, 5'd9, 32'h77, 32'hA5, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 1'b0, 5'd4, 5'd0, 32'h77, 32'h0, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 1'b0, 5'd4, 5'd6, 32'h77, 32'h0, 1'b1, 1'b0};
      tbl[12] = '{1'b1, 5'd6, 32'h66,       1'b0, 5'd0, 1'b0, 5'd6, 5'd4, 32'h66, 32'h77, 1'b0, 1'b1};
      tbl[13] = '{1'b1, 5'd4, 32'h88,       1'b1, 5'd6, 1'b0, 5'd4, 5'd6, 32'h88, 32'h66, 1'b0, 1'b1};
      model_reset();
      repeat (2) @(posedge CLK);
      #20 RESET_N = 1'b1;
      OUT1ADDRESS = 5'd5; OUT2ADDRESS = 5'd31;
      #1;
      chk("rst_out1", OUT1, 0); chk("rst_out2", OUT2, 0);
      chk("rst_busy1", BUSY1, 0); chk("rst_busy2", BUSY2, 0);

      foreach (tbl[i]) begin
         apply(tbl[i].w, tbl[i].ia, tbl[i].d, tbl[i].r, tbl[i].ra, tbl[i].f);
         tick();
         apply(0, 0, 0, 0, 0, 0);
         OUT1ADDRESS = tbl[i].a1; OUT2ADDRESS = tbl[i].a2;
         #1;
         chk($sformatf("vec%0d_out1", i), OUT1, tbl[i].e1);
         chk($sformatf("vec%0d_out2", i), OUT2, tbl[i].e2);
         chk($sformatf("vec%0d_busy1", i), BUSY1, tbl[i].b1);
         chk($sformatf("vec%0d_busy2", i), BUSY2, tbl[i].b2);
      end

      apply(1, 3, 32'h1111, 0, 0, 0);
      tick();
      apply(1, 3, 32'hCAFE, 1, 8, 0);
      OUT1ADDRESS = 5'd3; OUT2ADDRESS = 5'd0;
      #1;
      chk("byp_out1", OUT1, BYP ? 32'hCAFE : 32'h1111);
      chk("byp_busy1", BUSY1, 0);
      tick();
      apply(1, 3, 32'hBEEF, 1, 3, 0);
      #1;
      chk("byp_rsv_out1", OUT1, 32'hCAFE);
      chk("byp_rsv_busy1", BUSY1, 0);
      tick();
      apply(1, 0, 32'h9999, 0, 0, 0);
      OUT2ADDRESS = 5'd0;
      #1;
      chk("byp_r0_out2", OUT2, 0);
      chk("after_rsv_out1", OUT1, 32'hBEEF);
      chk("after_rsv_busy1", BUSY1, 1);
      tick();

      repeat (400) begin
         logic [4:0] m;
         m = ($urandom_range(0, 1) != 0) ? 5'd7 : 5'd31;
         apply($urandom_range(0, 1), 5'($urandom) & m, $urandom, $urandom_range(0, 1),
               5'($urandom) & m, $urandom_range(0, 15) == 0);
         OUT1ADDRESS = 5'($urandom) & m; OUT2ADDRESS = 5'($urandom) & m;
         check_reads("rand");
         tick();
      end
      apply(0, 0, 0, 0, 0, 0);

      p_w = 1'b1; p_ia = 3'd0; p_in = 64'hFFFF_FFFF_FFFF_FFFF;
      @(posedge CLK); #1;
      p_w = 1'b0; p_a1 = 3'd0; #1;
      chk("p64_r0", p_o1, 64'hFFFF_FFFF_FFFF_FFFF);
      for (int i = 1; i < 8; i++) begin
         p_w = 1'b1; p_ia = 3'(i); p_in = {32'(i * 3 + 1), 32'hA5A5_0000 | 32'(i)};
         @(posedge CLK); #1;
      end
      p_w = 1'b0; p_r = 1'b1; p_ra = 3'd0;
      @(posedge CLK); #1;
      p_r = 1'b0;
      for (int i = 0; i < 8; i++) begin
         p_a1 = 3'(i); p_a2 = 3'(7 - i); #1;
         chk($sformatf("p64_reg%0d", i), p_o1,
             i == 0 ? 64'hFFFF_FFFF_FFFF_FFFF : {32'(i * 3 + 1), 32'hA5A5_0000 | 32'(i)});
         chk($sformatf("p64_busy%0d", 7 - i), p_b2, i == 7);
      end

      @(posedge CLK); #1;
      apply(1, 5, 32'hFFFF, 1, 5, 0);
      RESET_N = 1'b0;
      model_reset();
      for (int i = 0; i < 32; i++) begin
         OUT1ADDRESS = 5'(i); OUT2ADDRESS = 5'(31 - i); #1;
         chk($sformatf("arst_out1_%0d", i), OUT1, 0);
         chk($sformatf("arst_out2_%0d", i), OUT2, 0);
         chk($sformatf("arst_busy1_%0d", i), BUSY1, 0);
         chk($sformatf("arst_busy2_%0d", i), BUSY2, 0);
      end
      p_a1 = 3'd0; #1;
      chk("arst_p64", p_o1, 0);
      @(posedge CLK); #1;
      OUT1ADDRESS = 5'd5; #1;
      chk("rst_held_out1", OUT1, 0);
      #20 RESET_N = 1'b1;
      check_reads("rel");
      tick();
      apply(0, 0, 0, 0, 0, 0);
      OUT1ADDRESS = 5'd5; OUT2ADDRESS = 5'd4;
      check_reads("post_rst");
      chk("post_rst_w", OUT1, 32'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
